dma_channel_scheduler: RTL and testbench
========================================

Name: dma_channel_scheduler

Overview:
- Shares one dma_master engine among NUM_CH requesting channels.
- Each channel posts a descriptor (source, destination, length) and a request. The scheduler picks a winner round-robin, latches its descriptor, and pulses the engine trigger.
- It then waits for the engine's done pulse and returns a per-channel completion or error pulse.
- It also guards the engine with a watchdog timeout and rejects lengths the engine cannot execute.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before the transfer is aborted (>=2).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel request; held until that channel's ch_done or ch_err.
- ch_src  in  NUM_CH*32  packed source addresses; channel i at [32i+31:32i].
- ch_dst  in  NUM_CH*32  packed destination addresses.
- ch_len  in  NUM_CH*5  packed byte lengths.
- ch_grant  out  NUM_CH  one-hot; high while the channel owns the engine.
- ch_done  out  NUM_CH  one-cycle completion pulse.
- ch_err  out  NUM_CH  one-cycle reject/timeout pulse.
- dma_trigger  out  1  one-cycle start pulse to the engine.
- dma_src  out  32  latched source address.
- dma_dst  out  32  latched destination address.
- dma_len  out  5  latched length.
- dma_done  in  1  engine completion pulse.
- dma_soft_reset  out  1  one-cycle engine reset pulse on timeout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: asynchronous and active-high; clock and reset ports are clk and reset.
  - All outputs reset to 0; state=IDLE; rr_ptr=0; timer=0.
  - All outputs are registered.
- States: IDLE, LAUNCH, WAIT, CMPL, ABORT, REJECT.
- IDLE:
  - If ch_req != 0, select the winner: the first set bit searching upward from rr_ptr, wrapping at NUM_CH-1.
  - At that edge: ch_grant[win]<=1; dma_src/dst/len <= channel win's descriptor; latch win_idx.
  - Next state: REJECT if ch_len[win][4:2]==0 (fewer than one word), else LAUNCH.
  - If no request, stay IDLE.
- LAUNCH: dma_trigger=1 for exactly this one cycle; timer<=0; -> WAIT.
- WAIT:
  - Timer increments each cycle.
  - If dma_done=1: -> CMPL. dma_done wins if it coincides with timeout.
  - Else if timer==TIMEOUT_CYCLES-1: -> ABORT.
- CMPL: ch_done[win_idx]=1 for one cycle; ch_grant<=0; rr_ptr<=(win_idx+1) mod NUM_CH; -> IDLE.
- ABORT: dma_soft_reset=1 and ch_err[win_idx]=1 for one cycle; ch_grant<=0; rr_ptr advances as in CMPL; -> IDLE.
- REJECT: ch_err[win_idx]=1 for one cycle; dma_trigger is never asserted; ch_grant<=0; rr_ptr advances; -> IDLE.
- Latency:
  - Request seen in IDLE at edge N gives grant at N+1 and trigger high during cycle N+1..N+2.
  - dma_done at edge M gives ch_done high during M+1..M+2, and busy low from M+2.
- Descriptor stability:
  - Descriptors are sampled only at grant.
  - Changes to ch_src/ch_dst/ch_len afterward are ignored.
  - dma_src/dst/len hold their values until the next grant.
- Request drop: if ch_req[win] drops mid-transfer, the transfer still completes and the done/err pulse is still issued.
- Stray done: dma_done outside WAIT is ignored.
- Minimum re-arbitration: the cycle after CMPL/ABORT/REJECT is IDLE. A requester must drop ch_req in the cycle after its pulse, or it is re-served as a new request.
- Fairness: a channel with a pending request waits at most NUM_CH-1 other transfers.
- Widths: rr_ptr and win_idx are $clog2(NUM_CH) bits; timer is $clog2(TIMEOUT_CYCLES) bits with no overflow past the compare.
- Reset mid-operation:
  - Immediate return to IDLE; all pulses cleared.
  - No dma_soft_reset is issued; the engine shares the reset.

Decomposition:
- Package dma_pkg:
  - DMA_ADDR_W=32 and DMA_LEN_W=5 constants.
  - sched_state_t enum (IDLE, LAUNCH, WAIT, CMPL, ABORT, REJECT).
  - Function len_valid(len) returning len[4:2]!=0.
- Sub-module dma_rr_arbiter:
  - Purely combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, win_idx and any_req.
- The scheduler FSM, timer and descriptor latch live in the top.

Test Plan:
- Basic transfer: ch_req[1]=1 with src=0x1000, dst=0x2000, len=16 -> ch_grant=0010 one cycle later; a single dma_trigger pulse with dma_src=0x1000, dma_dst=0x2000, dma_len=16; dma_done after 40 cycles -> one ch_done[1] pulse, busy low two cycles after done.
- Round-robin: all four ch_req asserted together after reset -> service order 0,1,2,3. Then serve ch1 alone, then request ch0 and ch2 together -> ch2 served before ch0.
- Reject: ch2 with len=3 -> ch_err[2] pulse, dma_trigger never asserted, rr_ptr=3 afterward.
- Timeout: TIMEOUT_CYCLES=64 and dma_done withheld -> ABORT entered 64 cycles after WAIT entry; dma_soft_reset and ch_err[win] pulse together; ch_done is never asserted.
- Done/timeout collision: TIMEOUT_CYCLES=64 and dma_done on the exact timeout cycle -> ch_done pulse; no ch_err or dma_soft_reset.
- Reset mid-transfer: reset asserted in WAIT, between clock edges -> ch_grant, busy and dma_trigger go to 0 immediately; after release a new request on ch3 is served first (rr_ptr=0 search).

Source files
------------

// File: rtl/dma_pkg.sv
// Shared constants, scheduler state encoding and descriptor helpers for the DMA channel scheduler.
package dma_pkg;

  localparam int DMA_ADDR_W = 32;
  localparam int DMA_LEN_W  = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    CMPL   = 3'd3,
    ABORT  = 3'd4,
    REJECT = 3'd5
  } sched_state_t;

  // The engine moves whole words only, so anything shorter than 4 bytes is unexecutable.
  function automatic logic len_valid(input logic [DMA_LEN_W-1:0] len);
    return len[4:2] != 3'd0;
  endfunction

endpackage

// File: rtl/dma_channel_scheduler_if.sv
// Channel-side request/descriptor bus plus engine-side control bus of the DMA scheduler.
// master = the scheduler, slave = the requesting channels and the engine.
interface dma_channel_scheduler_if #(
  parameter int NUM_CH = 4
);
  import dma_pkg::*;

  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH*DMA_ADDR_W-1:0] ch_src;
  logic [NUM_CH*DMA_ADDR_W-1:0] ch_dst;
  logic [NUM_CH*DMA_LEN_W-1:0]  ch_len;
  logic [NUM_CH-1:0]            ch_grant;
  logic [NUM_CH-1:0]            ch_done;
  logic [NUM_CH-1:0]            ch_err;
  logic                         dma_trigger;
  logic [DMA_ADDR_W-1:0]        dma_src;
  logic [DMA_ADDR_W-1:0]        dma_dst;
  logic [DMA_LEN_W-1:0]         dma_len;
  logic                         dma_done;
  logic                         dma_soft_reset;
  logic                         busy;

  modport master (
    input  ch_req, ch_src, ch_dst, ch_len, dma_done,
    output ch_grant, ch_done, ch_err, dma_trigger, dma_src, dma_dst, dma_len,
           dma_soft_reset, busy
  );

  modport slave (
    output ch_req, ch_src, ch_dst, ch_len, dma_done,
    input  ch_grant, ch_done, ch_err, dma_trigger, dma_src, dma_dst, dma_len,
           dma_soft_reset, busy
  );

endinterface

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr, wrapping past NUM_CH-1.
module dma_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [PTR_W-1:0]  win_idx,
  output logic              any_req
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant   = '0;
    win_idx = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/dma_channel_scheduler.sv
// Shares one DMA engine among NUM_CH channels: round-robin grant, descriptor latch, watchdog, length reject.
// Grant/trigger one cycle after a request is seen in IDLE; ch_done one cycle after dma_done; all outputs registered.
module dma_channel_scheduler
  import dma_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  dma_channel_scheduler_if.master bus
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  sched_state_t          state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      win_idx;
  logic [TMR_W-1:0]      timer;

  logic [NUM_CH-1:0]     arb_grant;
  logic [PTR_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [DMA_ADDR_W-1:0] sel_src;
  logic [DMA_ADDR_W-1:0] sel_dst;
  logic [DMA_LEN_W-1:0]  sel_len;
  logic [PTR_W-1:0]      rr_next;

  dma_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req     (bus.ch_req),
    .rr_ptr  (rr_ptr),
    .grant   (arb_grant),
    .win_idx (arb_idx),
    .any_req (arb_any)
  );

  assign sel_src = bus.ch_src[int'(arb_idx)*DMA_ADDR_W +: DMA_ADDR_W];
  assign sel_dst = bus.ch_dst[int'(arb_idx)*DMA_ADDR_W +: DMA_ADDR_W];
  assign sel_len = bus.ch_len[int'(arb_idx)*DMA_LEN_W +: DMA_LEN_W];
  assign rr_next = (win_idx == PTR_W'(NUM_CH-1)) ? '0 : win_idx + 1'b1;

  // Pulses are raised on the edge that enters their state so they line up with it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      win_idx            <= '0;
      timer              <= '0;
      bus.ch_grant       <= '0;
      bus.ch_done        <= '0;
      bus.ch_err         <= '0;
      bus.dma_trigger    <= 1'b0;
      bus.dma_src        <= '0;
      bus.dma_dst        <= '0;
      bus.dma_len        <= '0;
      bus.dma_soft_reset <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.ch_done        <= '0;
      bus.ch_err         <= '0;
      bus.dma_trigger    <= 1'b0;
      bus.dma_soft_reset <= 1'b0;
      case (state)
        IDLE: begin
          bus.busy <= arb_any;
          if (arb_any) begin
            bus.ch_grant <= arb_grant;
            bus.dma_src  <= sel_src;
            bus.dma_dst  <= sel_dst;
            bus.dma_len  <= sel_len;
            win_idx      <= arb_idx;
            if (len_valid(sel_len)) begin
              state           <= LAUNCH;
              bus.dma_trigger <= 1'b1;
            end else begin
              state      <= REJECT;
              bus.ch_err <= arb_grant;
            end
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the timeout cycle still counts as a completion.
          if (bus.dma_done) begin
            state       <= CMPL;
            bus.ch_done <= bus.ch_grant;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES-1)) begin
            state              <= ABORT;
            bus.ch_err         <= bus.ch_grant;
            bus.dma_soft_reset <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CMPL, ABORT, REJECT: begin
          bus.ch_grant <= '0;
          bus.busy     <= 1'b0;
          rr_ptr       <= rr_next;
          state        <= IDLE;
        end
        default: begin
          bus.ch_grant <= '0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Randomised and directed checks of dma_channel_scheduler against a transaction-level model.
module tb_dma_channel_scheduler;

  localparam int NCH = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic reset;

  dma_channel_scheduler_if #(.NUM_CH(NCH)) intf();

  dma_channel_scheduler #(
    .NUM_CH         (NCH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed pulse totals.
  int trig_cnt = 0, done_cnt = 0, err_cnt = 0, sr_cnt = 0;
  // Expected pulse totals.
  int exp_trig = 0, exp_done = 0, exp_err = 0, exp_sr = 0;

  always @(negedge clk) begin
    if (!reset) begin
      trig_cnt <= trig_cnt + int'(intf.dma_trigger);
      done_cnt <= done_cnt + $countones(intf.ch_done);
      err_cnt  <= err_cnt + $countones(intf.ch_err);
      sr_cnt   <= sr_cnt + int'(intf.dma_soft_reset);
    end
  end

  // Model state: pending requests, descriptors as posted, round-robin pointer.
  logic [NCH-1:0] mask;
  logic [31:0]    m_src [NCH];
  logic [31:0]    m_dst [NCH];
  logic [4:0]     m_len [NCH];
  int             ptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Nearest pending channel at or after ptr, measured as circular distance.
  function automatic int pick(input logic [NCH-1:0] m, input int p);
    int best  = -1;
    int bestd = NCH;
    for (int c = 0; c < NCH; c++) begin
      if (m[c] && ((c - p + NCH) % NCH) < bestd) begin
        bestd = (c - p + NCH) % NCH;
        best  = c;
      end
    end
    return best;
  endfunction

  task automatic post(input int c, input logic [31:0] s, input logic [31:0] d, input logic [4:0] l);
    m_src[c] = s;
    m_dst[c] = d;
    m_len[c] = l;
    intf.ch_src[c*32 +: 32] = s;
    intf.ch_dst[c*32 +: 32] = d;
    intf.ch_len[c*5 +: 5]   = l;
    intf.ch_req[c]          = 1'b1;
    mask[c]                 = 1'b1;
  endtask

  // Waits for the grant, then raises dma_done done_at cycles after the launch cycle (0 = never).
  task automatic transfer(input int ch, input int done_at);
    int  t0_trig = trig_cnt;
    bit  got     = 0;
    bit  rej     = (m_len[ch] < 5'd4);
    bit  cmpl    = !rej && done_at >= 1 && done_at <= TMO;
    int  exp_t   = rej ? 0 : (cmpl ? done_at + 1 : TMO + 1);
    int  t_evt   = -1;
    logic [NCH-1:0] done_v = '0, err_v = '0, g_v = '0;
    logic sr_v = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (intf.ch_grant != '0) begin
        got = 1;
        break;
      end
    end
    check("grant", intf.ch_grant, 64'(1) << ch);
    if (!got) return;
    check("dma_src", intf.dma_src, m_src[ch]);
    check("dma_dst", intf.dma_dst, m_dst[ch]);
    check("dma_len", intf.dma_len, m_len[ch]);
    intf.ch_src[ch*32 +: 32] = $urandom;
    intf.ch_dst[ch*32 +: 32] = $urandom;
    intf.ch_len[ch*5 +: 5]   = 5'($urandom);
    for (int i = 0; i <= TMO + 10; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) begin
        check("trigger_at_grant", intf.dma_trigger, !rej);
        check("busy_at_grant", intf.busy, 1);
      end
      if (intf.ch_done != '0 || intf.ch_err != '0) begin
        t_evt  = i;
        done_v = intf.ch_done;
        err_v  = intf.ch_err;
        sr_v   = intf.dma_soft_reset;
        g_v    = intf.ch_grant;
        break;
      end
      intf.dma_done = (i == done_at);
    end
    intf.dma_done   = 1'b0;
    intf.ch_req[ch] = 1'b0;
    mask[ch]        = 1'b0;
    check("event_cycle", 64'(t_evt), 64'(exp_t));
    check("ch_done", done_v, cmpl ? (64'(1) << ch) : 64'(0));
    check("ch_err", err_v, cmpl ? 64'(0) : (64'(1) << ch));
    check("soft_reset", sr_v, !rej && !cmpl);
    check("grant_held", g_v, 64'(1) << ch);
    check("desc_stable", {intf.dma_src, intf.dma_dst, intf.dma_len[4:0]},
          {m_src[ch], m_dst[ch], m_len[ch]});
    @(negedge clk);
    ptr = (ch + 1) % NCH;
    check("busy_after", intf.busy, 0);
    check("grant_after", intf.ch_grant, 0);
    check("pulse_width", intf.ch_done | intf.ch_err, 0);
    check("trigger_count", 64'(trig_cnt - t0_trig), rej ? 64'(0) : 64'(1));
    check("rr_ptr", dut.rr_ptr, 64'(ptr));
    if (rej) exp_err++;
    else begin
      exp_trig++;
      if (cmpl) exp_done++;
      else begin
        exp_err++;
        exp_sr++;
      end
    end
  endtask

  initial begin
    int d0;
    logic [NCH-1:0] nr;
    reset         = 1'b1;
    intf.ch_req   = '0;
    intf.ch_src   = '0;
    intf.ch_dst   = '0;
    intf.ch_len   = '0;
    intf.dma_done = 1'b0;
    mask          = '0;
    ptr           = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {intf.ch_grant, intf.ch_done, intf.ch_err, intf.dma_trigger,
                            intf.dma_soft_reset, intf.busy, intf.dma_src, intf.dma_len}, 0);
    check("reset_rr_ptr", dut.rr_ptr, 0);
    reset = 1'b0;

    // Basic transfer on channel 1.
    @(negedge clk);
    post(1, 32'h1000, 32'h2000, 5'd16);
    transfer(1, 40);

    // Round-robin from a fresh reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ptr   = 0;
    for (int c = 0; c < NCH; c++) post(c, 32'h100 * (c + 1), 32'h9000 + c, 5'd8 + 5'(c));
    for (int c = 0; c < NCH; c++) transfer(c, 3 + c);
    post(1, 32'hA0, 32'hB0, 5'd12);
    transfer(1, 5);
    post(0, 32'hC0, 32'hD0, 5'd20);
    post(2, 32'hE0, 32'hF0, 5'd24);
    transfer(2, 7);
    transfer(0, 2);

    // Unexecutable length, watchdog abort, done on the timeout cycle.
    post(2, 32'h1234, 32'h5678, 5'd3);
    transfer(2, 10);
    post(3, 32'h3000, 32'h4000, 5'd31);
    transfer(3, 0);
    post(0, 32'h5000, 32'h6000, 5'd4);
    transfer(0, TMO);

    // A done pulse while idle must do nothing.
    d0 = done_cnt;
    intf.dma_done = 1'b1;
    @(negedge clk);
    intf.dma_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_done_busy", intf.busy, 0);
    check("stray_done_pulses", 64'(done_cnt - d0), 0);

    // Reset while the engine is busy.
    post(1, 32'h7000, 32'h8000, 5'd8);
    for (int i = 0; i < 20 && intf.ch_grant == '0; i++) @(negedge clk);
    check("pre_reset_grant", intf.ch_grant, 4'b0010);
    exp_trig++;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_outputs", {intf.ch_grant, intf.busy, intf.dma_trigger, intf.dma_soft_reset}, 0);
    check("mid_reset_rr_ptr", dut.rr_ptr, 0);
    intf.ch_req = '0;
    mask        = '0;
    ptr         = 0;
    @(negedge clk);
    reset = 1'b0;
    post(3, 32'hABCD0000, 32'h0000DCBA, 5'd28);
    transfer(3, 5);

    // Random traffic.
    for (int it = 0; it < 24; it++) begin
      nr = NCH'($urandom_range(0, (1 << NCH) - 1)) & ~mask;
      if ((mask | nr) == '0) nr[$urandom_range(0, NCH - 1)] = 1'b1;
      for (int c = 0; c < NCH; c++)
        if (nr[c]) post(c, $urandom, $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) d0 = $urandom_range(TMO - 4, TMO + 4);
      else d0 = $urandom_range(1, 30);
      transfer(pick(mask, ptr), d0);
    end
    while (mask != '0) transfer(pick(mask, ptr), $urandom_range(1, 20));

    @(negedge clk);
    check("total_triggers", 64'(trig_cnt), 64'(exp_trig));
    check("total_done", 64'(done_cnt), 64'(exp_done));
    check("total_err", 64'(err_cnt), 64'(exp_err));
    check("total_soft_reset", 64'(sr_cnt), 64'(exp_sr));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
